skinny_sbox_layer_seq: RTL and testbench
========================================

Name: skinny_sbox_layer_seq

Overview:
- Sequences the SubCells layer of a first-order masked SKINNY round over a 128-bit, 2-share state using NSBOX instances of the 4-cycle, non-pipelined masked sbox8 (16 refresh bits each).
- Feeds byte groups to the sboxes and holds their inputs and masks stable for the full evaluation.
- Pulls fresh randomness per group through a valid/ready handshake and reassembles the substituted shares.
- Sits between the round controller and the sbox instances.

Parameters:
- NSBOX, 1, sbox instances in parallel; legal values 1, 2, 4, 8, 16.
- LAT, 4, sbox depth in clock cycles.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin layer; sampled only in IDLE.
- st_in0, st_in1  input  128  state shares; byte k = bits [8k+7:8k].
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the layer is complete.
- st_out0, st_out1  output  128  substituted shares.
- rnd_valid  input  1  randomness source has data.
- rnd_data  input  16*NSBOX  fresh mask bits.
- rnd_ready  output  1  high in LOAD.
- sb_in0, sb_in1  output  8*NSBOX  sbox input shares; lane j = byte g*NSBOX+j.
- sb_r  output  16*NSBOX  sbox refresh masks; lane j = bits [16j+15:16j].
- sb_out0, sb_out1  input  8*NSBOX  sbox output shares.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, rnd_ready=0; st_out*, sb_in*, sb_r, group counter and cycle counter all 0. Applies mid-operation; partial results are discarded.
- FSM states: IDLE, LOAD, HOLD, DONE. G = 16/NSBOX groups.
- IDLE:
  - start=1 at edge S: latch st_in0/st_in1 into internal shares; g=0; go to LOAD.
  - st_in is ignored outside this edge.
- LOAD:
  - rnd_ready=1.
  - Edge E0 with rnd_valid=1: sb_in* <= group g bytes, sb_r <= rnd_data, cnt=0, go to HOLD.
  - rnd_valid=0: stay in LOAD and stall indefinitely; sb_in* and sb_r are unchanged.
- HOLD:
  - rnd_ready=0; sb_in* and sb_r are frozen.
  - cnt increments each edge.
  - At edge E0+LAT+1 (cnt==LAT): capture sb_out* into byte positions g*NSBOX..g*NSBOX+NSBOX-1 of st_out*.
  - Then: if g==G-1 go to DONE, else g++ and go to LOAD.
- DONE: done=1 for exactly one cycle, then IDLE. st_out* holds until the first capture of the next layer.
- Group period with rnd_valid tied high: LAT+2 cycles.
- Latency with LAT=4: start edge S to done-high cycle = G*6 edges. Example: NSBOX=1, done is high in the cycle following edge S+96.
- start while busy=1 is ignored; no queuing.
- Each rnd_data word is consumed by exactly one group. Masks are never reused across groups.
- rnd_valid dropping during HOLD has no effect.
- st_out* bytes not yet rewritten in the current layer keep their previous-layer values.

Optional Feature:
- Macro: SBOX_IDLE_CLEAR_EN.
- Defined:
  - sb_in0, sb_in1 and sb_r are driven to 0 in every cycle not in HOLD (IDLE, LOAD, DONE). This limits share recombination through sbox glitches between groups.
  - LOAD-edge loading and all HOLD behaviour are unchanged.
- Undefined: sb_in* and sb_r retain their last loaded values outside HOLD.

Test Plan:
- Reset: rst_n=0 mid-HOLD with NSBOX=1 -> all outputs 0 immediately. After release, start -> full layer runs from byte 0.
- Nominal, NSBOX=1, LAT=4, rnd_valid=1, shares st_in0=0x00..0F, st_in1=random -> done in the cycle after edge S+96; st_out0^st_out1 = SKINNY S8 of each byte of st_in0^st_in1 (S8(0x00)=0x65).
- Stall: rnd_valid=0 for 10 cycles at group 3 -> done delayed by exactly 10 cycles. sb_in*/sb_r stable during the stall. Each rnd_data word observed once on sb_r.
- Stability: monitor sb_in*/sb_r across every HOLD -> no change across LAT+1 edges. sb_out captured exactly at cnt==LAT.
- Parallel: NSBOX=4, same vectors -> identical unmasked result; done after 4*6=24 edges.
- Busy start: start pulsed during HOLD -> ignored. Result and timing identical to the baseline run. With SBOX_IDLE_CLEAR_EN, sb_in*/sb_r are 0 in every LOAD cycle.

Source files
------------

// File: rtl/skinny_sbox_layer_seq.sv
// Masked SKINNY SubCells sequencer: feeds NSBOX masked sbox8 lanes one byte group at a time and reassembles the shares.
// Latency: (16/NSBOX)*(LAT+2) cycles from start to done while rnd_valid stays high; optional SBOX_IDLE_CLEAR_EN.
// Backpressure: waits in LOAD for as long as rnd_valid is low; start is ignored while busy.
module skinny_sbox_layer_seq #(
  parameter int NSBOX = 1,
  parameter int LAT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [127:0]          st_in0,
  input  logic [127:0]          st_in1,
  output logic                  busy,
  output logic                  done,
  output logic [127:0]          st_out0,
  output logic [127:0]          st_out1,
  input  logic                  rnd_valid,
  input  logic [16*NSBOX-1:0]   rnd_data,
  output logic                  rnd_ready,
  output logic [8*NSBOX-1:0]    sb_in0,
  output logic [8*NSBOX-1:0]    sb_in1,
  output logic [16*NSBOX-1:0]   sb_r,
  input  logic [8*NSBOX-1:0]    sb_out0,
  input  logic [8*NSBOX-1:0]    sb_out1
);

  localparam int G  = 16 / NSBOX;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, DONE} state_t;

  state_t state_q, state_d;

  // Shares viewed as G groups so the active group is a plain index.
  logic [G-1:0][8*NSBOX-1:0] sh0_q, sh1_q;
  logic [G-1:0][8*NSBOX-1:0] out0_q, out1_q;
  logic [GW-1:0]             grp_q;
  logic [CW-1:0]             cnt_q;
  logic [8*NSBOX-1:0]        ld_in0_q, ld_in1_q;
  logic [16*NSBOX-1:0]       ld_r_q;
  logic                      cap;
  logic                      last_grp;

  assign cap      = (state_q == HOLD) && (cnt_q == CW'(LAT));
  assign last_grp = (grp_q == GW'(G - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    done      = 1'b0;
    rnd_ready = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = LOAD;
      end
      LOAD: begin
        rnd_ready = 1'b1;
        if (rnd_valid) state_d = HOLD;
      end
      HOLD: begin
        if (cap) state_d = last_grp ? DONE : LOAD;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh0_q    <= '0;
      sh1_q    <= '0;
      out0_q   <= '0;
      out1_q   <= '0;
      grp_q    <= '0;
      cnt_q    <= '0;
      ld_in0_q <= '0;
      ld_in1_q <= '0;
      ld_r_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            sh0_q <= st_in0;
            sh1_q <= st_in1;
            grp_q <= '0;
          end
        end
        LOAD: begin
          // One randomness word per group; it stays on sb_r for the whole evaluation.
          if (rnd_valid) begin
            ld_in0_q <= sh0_q[grp_q];
            ld_in1_q <= sh1_q[grp_q];
            ld_r_q   <= rnd_data;
            cnt_q    <= '0;
          end
        end
        HOLD: begin
          cnt_q <= cnt_q + 1'b1;
          if (cap) begin
            out0_q[grp_q] <= sb_out0;
            out1_q[grp_q] <= sb_out1;
            if (!last_grp) grp_q <= grp_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign st_out0 = out0_q;
  assign st_out1 = out1_q;

`ifdef SBOX_IDLE_CLEAR_EN
  // Keep sbox inputs quiet between groups so stale shares cannot recombine through glitches.
  assign sb_in0 = (state_q == HOLD) ? ld_in0_q : '0;
  assign sb_in1 = (state_q == HOLD) ? ld_in1_q : '0;
  assign sb_r   = (state_q == HOLD) ? ld_r_q   : '0;
`else
  assign sb_in0 = ld_in0_q;
  assign sb_in1 = ld_in1_q;
  assign sb_r   = ld_r_q;
`endif

endmodule

// File: tb/tb_skinny_sbox_layer_seq.sv
// Bench for skinny_sbox_layer_seq: NSBOX=1 instance checked cycle by cycle against a schedule model,
// NSBOX=4 instance checked for latency and unmasked result; both driven by behavioural masked sbox models.
module tb_skinny_sbox_layer_seq;
  localparam int LAT = 4;
  localparam logic [127:0] BYTES = 128'h0F0E0D0C0B0A09080706050403020100;
`ifdef SBOX_IDLE_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic [127:0] st_in0, st_in1;

  logic start1, busy1, done1, rv1, rr1;
  logic [15:0] rd1, sbr1;
  logic [127:0] so0_1, so1_1;
  logic [7:0] sbi0_1, sbi1_1, sbo0_1, sbo1_1;

  logic start4, busy4, done4, rv4, rr4;
  logic [63:0] rd4, sbr4;
  logic [127:0] so0_4, so1_4;
  logic [31:0] sbi0_4, sbi1_4, sbo0_4, sbo1_4;

  int n_chk, n_pass;

  skinny_sbox_layer_seq #(.NSBOX(1), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .st_in0(st_in0), .st_in1(st_in1),
    .busy(busy1), .done(done1), .st_out0(so0_1), .st_out1(so1_1),
    .rnd_valid(rv1), .rnd_data(rd1), .rnd_ready(rr1),
    .sb_in0(sbi0_1), .sb_in1(sbi1_1), .sb_r(sbr1), .sb_out0(sbo0_1), .sb_out1(sbo1_1));

  skinny_sbox_layer_seq #(.NSBOX(4), .LAT(LAT)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .st_in0(st_in0), .st_in1(st_in1),
    .busy(busy4), .done(done4), .st_out0(so0_4), .st_out1(so1_4),
    .rnd_valid(rv4), .rnd_data(rd4), .rnd_ready(rr4),
    .sb_in0(sbi0_4), .sb_in1(sbi1_4), .sb_r(sbr4), .sb_out0(sbo0_4), .sb_out1(sbo1_4));

  function automatic logic [7:0] mix(input logic [7:0] x);
    logic [7:0] t;
    t = ~(((x >> 1) | x) >> 2);
    return (t & 8'h11) ^ x;
  endfunction

  function automatic logic [7:0] perm(input logic [7:0] x);
    return ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5) |
           ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
  endfunction

  // SKINNY-128 S8 from its mix/permute round description.
  function automatic logic [7:0] s8(input logic [7:0] v);
    logic [7:0] x;
    x = v;
    for (int r = 0; r < 3; r++) begin
      x = mix(x);
      x = perm(x);
    end
    x = mix(x);
    return (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
  endfunction

  // Masked sbox behaviour: {out1, out0} with out0 ^ out1 = S8(a ^ b).
  function automatic logic [15:0] msbox(input logic [7:0] a, input logic [7:0] b, input logic [15:0] r);
    logic [7:0] o1;
    o1 = r[7:0] ^ r[15:8] ^ {b[3:0], b[7:4]};
    return {o1, s8(a ^ b) ^ o1};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] unmask(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] u;
    for (int k = 0; k < 16; k++) u[8*k +: 8] = s8(a[8*k +: 8] ^ b[8*k +: 8]);
    return u;
  endfunction

  // Sbox models: result of inputs sampled at an edge appears LAT edges later.
  logic [15:0] p1 [LAT];
  logic [63:0] p4 [LAT];
  always @(posedge clk) begin
    p1[0] <= msbox(sbi0_1, sbi1_1, sbr1);
    for (int k = 1; k < LAT; k++) p1[k] <= p1[k-1];
    for (int j = 0; j < 4; j++)
      p4[0][16*j +: 16] <= msbox(sbi0_4[8*j +: 8], sbi1_4[8*j +: 8], sbr4[16*j +: 16]);
    for (int k = 1; k < LAT; k++) p4[k] <= p4[k-1];
  end
  assign sbo0_1 = p1[LAT-1][7:0];
  assign sbo1_1 = p1[LAT-1][15:8];
  always_comb begin
    sbo0_4 = '0;
    sbo1_4 = '0;
    for (int j = 0; j < 4; j++) begin
      sbo0_4[8*j +: 8] = p4[LAT-1][16*j +: 8];
      sbo1_4[8*j +: 8] = p4[LAT-1][16*j+8 +: 8];
    end
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Schedule model of the NSBOX=1 instance.
  bit m_active, m_donep, seen_done;
  int m_grp, m_hold, cyc, s_cyc, stall_grp, stall_left, exp_lat;
  logic [127:0] m_a, m_b, m_out0, m_out1;
  logic [31:0] m_last;

  task automatic model_reset();
    m_active = 0; m_donep = 0; m_grp = 0; m_hold = 0;
    m_out0 = '0; m_out1 = '0; m_last = '0;
  endtask

  task automatic step(input bit st);
    logic [15:0] r;
    @(negedge clk);
    cyc++;
    chk("ctl", {busy1, done1, rr1}, {m_active | m_donep, m_donep, m_active && m_hold == 0});
    chk("st_out", {so0_1, so1_1}, {m_out0, m_out1});
    if (m_active && m_hold > 0) chk("sb_hold", {sbi0_1, sbi1_1, sbr1}, m_last);
    else chk("sb_idle", {sbi0_1, sbi1_1, sbr1}, CLR ? 32'h0 : m_last);
    if (m_donep) begin
      seen_done = 1;
      chk("latency", cyc - s_cyc - 1, exp_lat);
      chk("unmasked", so0_1 ^ so1_1, unmask(m_a, m_b));
    end
    start1 = st;
    if (!st) begin
      st_in0 = rand128();
      st_in1 = rand128();
    end
    rv1 = 1'b1;
    if (m_active && m_hold == 0 && m_grp == stall_grp && stall_left > 0) begin
      rv1 = 1'b0;
      stall_left--;
    end
    rd1 = 16'($urandom);
    if (m_donep) begin
      m_donep = 0;
    end else if (!m_active) begin
      if (st) begin
        m_active = 1; m_grp = 0; m_hold = 0;
        m_a = st_in0; m_b = st_in1; s_cyc = cyc;
      end
    end else if (m_hold == 0) begin
      if (rv1) begin
        m_last = {m_a[8*m_grp +: 8], m_b[8*m_grp +: 8], rd1};
        m_hold = LAT + 1;
      end
    end else begin
      m_hold--;
      if (m_hold == 0) begin
        r = msbox(m_last[31:24], m_last[23:16], m_last[15:0]);
        m_out0[8*m_grp +: 8] = r[7:0];
        m_out1[8*m_grp +: 8] = r[15:8];
        if (m_grp == 15) begin
          m_active = 0;
          m_donep = 1;
        end else begin
          m_grp++;
        end
      end
    end
  endtask

  task automatic run_layer(input int sg, input int sl, input int busy_at);
    stall_grp = sg;
    stall_left = sl;
    exp_lat = 16 * (LAT + 2) + sl;
    seen_done = 0;
    step(1'b1);
    for (int i = 1; i < 400 && !seen_done; i++) step(i == busy_at);
    chk("done_seen", seen_done, 1'b1);
  endtask

  task automatic run4(input logic [127:0] a, input logic [127:0] b);
    int c;
    bit seen;
    @(negedge clk);
    st_in0 = a;
    st_in1 = b;
    start4 = 1'b1;
    rd4 = {$urandom, $urandom};
    c = 0;
    seen = 0;
    while (!seen && c < 200) begin
      @(negedge clk);
      start4 = 1'b0;
      rd4 = {$urandom, $urandom};
      c++;
      if (done4) seen = 1;
    end
    chk("done4_seen", seen, 1'b1);
    chk("latency4", c - 1, 4 * (LAT + 2));
    chk("unmasked4", so0_4 ^ so1_4, unmask(a, b));
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; s_cyc = 0;
    start1 = 0; start4 = 0; rv1 = 0; rv4 = 1; rd1 = '0; rd4 = '0;
    st_in0 = '0; st_in1 = '0;
    stall_grp = -1; stall_left = 0; exp_lat = 0; seen_done = 0;
    model_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_init", {busy1, done1, rr1, so0_1, so1_1, sbi0_1, sbi1_1, sbr1}, '0);
    chk("rst_init4", {busy4, done4, rr4, so0_4, so1_4, sbi0_4, sbi1_4, sbr4}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    st_in0 = BYTES; st_in1 = rand128();
    run_layer(-1, 0, -1);

    // Equal shares: every unmasked byte is zero, so every output byte must be S8(0x00).
    st_in0 = rand128(); st_in1 = st_in0;
    run_layer(-1, 0, -1);
    chk("s8_zero", so0_1 ^ so1_1, {16{8'h65}});

    st_in0 = BYTES; st_in1 = rand128();
    run_layer(3, 10, -1);

    st_in0 = BYTES; st_in1 = rand128();
    run_layer(-1, 0, 3);

    // Reset while holding group 0 of a new layer.
    st_in0 = BYTES; st_in1 = rand128();
    step(1'b1);
    step(1'b0);
    step(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {busy1, done1, rr1, so0_1, so1_1, sbi0_1, sbi1_1, sbr1}, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    st_in0 = BYTES; st_in1 = rand128();
    run_layer(-1, 0, -1);

    run4(BYTES, rand128());
    run4(rand128(), rand128());

    for (int i = 0; i < 4; i++) begin
      st_in0 = rand128(); st_in1 = rand128();
      run_layer(int'($urandom_range(0, 15)), int'($urandom_range(0, 6)),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 90)) : -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
